// File: rtl/alu_pkg.sv
// Shared types for the accumulator and its ALU: opcodes, FSM states and result flags.
package alu_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_NOT  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_SLA  = 4'd6,
      OP_SLL  = 4'd7,
      OP_SRA  = 4'd8,
      OP_SRL  = 4'd9,
      OP_LOAD = 4'd10
   } alu_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_DONE
   } acc_state_t;

   typedef struct packed {
      logic cout;
      logic negative;
      logic zero;
   } alu_flags_t;

   // Opcodes above LOAD are reserved and must not touch the accumulator.
   function automatic logic op_legal(input logic [OP_W-1:0] op);
      return op <= OP_LOAD;
   endfunction

endpackage

// File: rtl/mod_alu.sv
// Combinational 10-operation ALU; LOAD and reserved opcodes produce zero here.
module mod_alu
   import alu_pkg::*;
#(
   parameter int unsigned width = 4
) (
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   input  logic [OP_W-1:0]  op,
   output logic [width-1:0] y,
   output alu_flags_t       flags
);

   logic [width:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   always_comb begin
      y     = '0;
      flags = '0;
      case (op)
         OP_ADD: begin
            y          = sum[width-1:0];
            flags.cout = sum[width];
         end
         // SUB returns the magnitude; the sign goes to the negative flag.
         OP_SUB: begin
            if (a < b) begin
               y              = b - a;
               flags.negative = 1'b1;
            end else begin
               y = a - b;
            end
         end
         OP_NOT:         y = ~a;
         OP_AND:         y = a & b;
         OP_OR:          y = a | b;
         OP_XOR:         y = a ^ b;
         OP_SLA, OP_SLL: y = {a[width-2:0], 1'b0};
         OP_SRA:         y = {a[width-1], a[width-1:1]};
         OP_SRL:         y = {1'b0, a[width-1:1]};
         default:        y = '0;
      endcase
      flags.zero = (y == '0);
   end

endmodule

// File: rtl/alu_accumulator.sv
// Accumulator sequencer: accepts a command, runs it through mod_alu against the
// accumulator, writes back and holds a registered response until it is consumed.
module alu_accumulator
   import alu_pkg::*;
#(
   parameter int unsigned width = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_op,
   input  logic [width-1:0] cmd_operand,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [width-1:0] res_value,
   output logic             res_cout,
   output logic             res_negative,
   output logic             res_zero,
   output logic             res_err
);

   acc_state_t       state;
   logic [width-1:0] acc;
   logic [width-1:0] operand_q;
   logic [OP_W-1:0]  op_q;

   logic [width-1:0] alu_y;
   alu_flags_t       alu_flags;

   logic             legal_c;
   logic [width-1:0] next_value_c;
   alu_flags_t       next_flags_c;

   mod_alu #(.width(width)) u_alu (
      .a     (acc),
      .b     (operand_q),
      .op    (op_q),
      .y     (alu_y),
      .flags (alu_flags)
   );

   // Result selection: LOAD bypasses the ALU, reserved opcodes echo the accumulator.
   always_comb begin
      legal_c      = op_legal(op_q);
      next_value_c = acc;
      next_flags_c = '0;
      if (op_q == OP_LOAD) begin
         next_value_c      = operand_q;
         next_flags_c.zero = (operand_q == '0);
      end else if (legal_c) begin
         next_value_c = alu_y;
         next_flags_c = alu_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         acc          <= '0;
         operand_q    <= '0;
         op_q         <= '0;
         cmd_ready    <= 1'b1;
         res_valid    <= 1'b0;
         res_value    <= '0;
         res_cout     <= 1'b0;
         res_negative <= 1'b0;
         res_zero     <= 1'b0;
         res_err      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  op_q      <= cmd_op;
                  operand_q <= cmd_operand;
                  cmd_ready <= 1'b0;
                  state     <= S_EXEC;
               end
            end
            S_EXEC: begin
               res_value    <= next_value_c;
               res_cout     <= next_flags_c.cout;
               res_negative <= next_flags_c.negative;
               res_zero     <= next_flags_c.zero;
               res_err      <= !legal_c;
               if (legal_c) begin
                  acc <= next_value_c;
               end
               res_valid <= 1'b1;
               state     <= S_DONE;
            end
            S_DONE: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator (width 4) with hand-computed expectations.
module tb_alu_accumulator;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [3:0] cmd_operand;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_value;
   logic       res_cout;
   logic       res_negative;
   logic       res_zero;
   logic       res_err;

   int errors = 0;
   int checks = 0;

   alu_accumulator #(.width(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_op       (cmd_op),
      .cmd_operand  (cmd_operand),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_value    (res_value),
      .res_cout     (res_cout),
      .res_negative (res_negative),
      .res_zero     (res_zero),
      .res_err      (res_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one command, check latency, check the response, then consume it.
   task automatic run_cmd(input string tag, input logic [3:0] op, input logic [3:0] operand,
                          input logic [3:0] value, input logic cout, input logic neg,
                          input logic zero, input logic err);
      int n;
      cmd_valid   = 1'b1;
      cmd_op      = op;
      cmd_operand = operand;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".accept"}, 32'(cmd_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, ".exec_valid"}, 32'(res_valid), 32'd0);
      @(negedge clk);
      n = 0;
      while (!res_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
      chk({tag, ".value"}, 32'(res_value), 32'(value));
      chk({tag, ".flags"}, 32'({res_cout, res_negative, res_zero, res_err}),
          32'({cout, neg, zero, err}));
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({tag, ".drop"}, 32'({res_valid, cmd_ready}), 32'b01);
   endtask

   initial begin
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_op      = 4'd0;
      cmd_operand = 4'd0;
      res_ready   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset.outputs", 32'({cmd_ready, res_valid, res_err, res_cout, res_negative, res_zero}),
          32'b100000);
      chk("reset.value", 32'(res_value), 32'd0);

      // op, operand -> value, cout, negative, zero, err
      run_cmd("load14", 4'd10, 4'd14, 4'd14, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("add5",   4'd0,  4'd5,  4'd3,  1'b1, 1'b0, 1'b0, 1'b0);
      run_cmd("load6a", 4'd10, 4'd6,  4'd6,  1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("sub10",  4'd1,  4'd10, 4'd4,  1'b0, 1'b1, 1'b0, 1'b0);
      run_cmd("add0",   4'd0,  4'd0,  4'd4,  1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("load6b", 4'd10, 4'd6,  4'd6,  1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("sub6",   4'd1,  4'd6,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0);
      run_cmd("load10", 4'd10, 4'd10, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("sra",    4'd8,  4'd7,  4'd13, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("srl",    4'd9,  4'd7,  4'd6,  1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("load7",  4'd10, 4'd7,  4'd7,  1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("ill12",  4'd12, 4'd3,  4'd7,  1'b0, 1'b0, 1'b0, 1'b1);
      run_cmd("not",    4'd2,  4'd5,  4'd8,  1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("or3",    4'd4,  4'd3,  4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("and6",   4'd3,  4'd6,  4'd2,  1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("xor15",  4'd5,  4'd15, 4'd13, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("sll",    4'd7,  4'd1,  4'd10, 1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("sla",    4'd6,  4'd1,  4'd4,  1'b0, 1'b0, 1'b0, 1'b0);
      run_cmd("ill15",  4'd15, 4'd9,  4'd4,  1'b0, 1'b0, 1'b0, 1'b1);
      run_cmd("and0",   4'd3,  4'd0,  4'd0,  1'b0, 1'b0, 1'b1, 1'b0);

      // Backpressure: response held while a new command waits.
      cmd_valid   = 1'b1;
      cmd_op      = 4'd10;
      cmd_operand = 4'd9;
      @(posedge clk);
      @(negedge clk);
      cmd_op      = 4'd0;
      cmd_operand = 4'd1;
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         chk("bp.hold_ctrl", 32'({res_valid, cmd_ready}), 32'b10);
         chk("bp.hold_data", 32'({res_value, res_cout, res_negative, res_zero, res_err}),
             32'({4'd9, 4'b0000}));
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("bp.handshake", 32'({res_valid, cmd_ready}), 32'b01);
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("bp.accepted", 32'(cmd_ready), 32'd0);
      @(negedge clk);
      chk("bp.second_valid", 32'(res_valid), 32'd1);
      chk("bp.second_value", 32'(res_value), 32'd10);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;

      // Reset during EXEC discards the in-flight command and clears the accumulator.
      run_cmd("load2", 4'd10, 4'd2, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
      cmd_valid   = 1'b1;
      cmd_op      = 4'd0;
      cmd_operand = 4'd3;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("rst.async", 32'({res_valid, cmd_ready, res_value}), 32'({2'b01, 4'd0}));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("rst.no_response", 32'(res_valid), 32'd0);
      end
      run_cmd("add1", 4'd0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_accumulator.md
# alu_accumulator

Sequential accumulator built around the team's 10-operation ALU. Each accepted command applies one ALU operation between an internal accumulator (operand A) and a command operand (operand B). The block writes the result back to the accumulator and returns result plus flags on a valid/ready response port. It sits between a command source (sequencer or UART command decoder) and the ALU: it drives the ALU rather than testing it.

## Interface
- `width`, 4, datapath width in bits (min 2)
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  block can accept a command
- `cmd_op`  in  4  operation code
- `cmd_operand`  in  width  operand B
- `res_valid`  out  1  response present
- `res_ready`  in  1  consumer accepts the response
- `res_value`  out  width  result, equal to the new accumulator value
- `res_cout`  out  1  carry flag
- `res_negative`  out  1  negative flag
- `res_zero`  out  1  zero flag
- `res_err`  out  1  illegal opcode

## Operation
- Opcodes (A = accumulator, B = operand):
  - 0 ADD: `A+B` mod 2^width; cout = carry out of the MSB.
  - 1 SUB: result = |A−B|; negative = (A<B); cout = 0.
  - 2 NOT: `~A`.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 arithmetic left shift by 1.
  - 7 logical left shift by 1.
  - 8 arithmetic right shift by 1 (MSB replicated).
  - 9 logical right shift by 1.
  - 10 LOAD: result = B.
- B is ignored for opcodes 2 and 6–9.
- Flags:
  - zero = (result == 0), for every legal opcode.
  - negative = 0 except for SUB.
  - cout = 0 except for ADD.
- Opcodes 11–15 are illegal:
  - res_err = 1, res_value = current accumulator, all three flags 0.
  - The accumulator is unchanged.
- The accumulator updates only on a legal opcode, at the end of EXEC.
- FSM states:
  - IDLE: cmd_ready = 1. On `cmd_valid & cmd_ready`, capture op and operand, go to EXEC.
  - EXEC: one cycle. Combinational ALU evaluates the captured op. Register result, flags and err. Update the accumulator. Go to DONE.
  - DONE: res_valid = 1. On `res_ready`, go to IDLE.
- cmd_ready is 0 in EXEC and DONE. A command presented then is not accepted and must be held by the source.
- Response outputs are registered and stay stable for the whole of DONE.
- Reset, asynchronous, may assert at any time including mid-EXEC or DONE:
  - state = IDLE, accumulator = 0, captured command cleared.
  - res_value = 0, all flags 0, res_err = 0, res_valid = 0, cmd_ready = 1 once rst_n deasserts.
  - An in-flight command is discarded without a response.

## Timing
- Cycle 0: command handshake at the rising edge in IDLE.
- Cycle 1: EXEC.
- Rising edge ending cycle 1: response registered; res_valid high from cycle 2.
- Minimum latency is 2 cycles from the accept edge to res_valid.
- Response handshake at the edge where `res_valid & res_ready`:
  - res_valid drops after that edge.
  - cmd_ready rises in the same cycle.
- Peak throughput is one command per 3 cycles.
- There is no combinational path from cmd_* or res_ready to any output.
- res_ready held low stalls indefinitely; nothing is lost or overwritten.

## Structure
- Package `alu_pkg`:
  - enum `alu_op_t` with `OP_ADD`…`OP_SRL` = 0–9 and `OP_LOAD` = 10.
  - enum `acc_state_t` with `S_IDLE`, `S_EXEC`, `S_DONE`.
  - struct `alu_flags_t` with fields cout, negative, zero.
- Sub-module `mod_alu`: the existing combinational ALU (parameter `width`), instantiated once. LOAD and illegal-opcode handling stay in `alu_accumulator`.

## Test plan
- Reset, then LOAD 14, then ADD 5 -> second response res_value = 3, cout = 1, zero = 0, err = 0.
- LOAD 6, then SUB 10 -> res_value = 4, negative = 1, cout = 0; following ADD 0 returns 4, confirming the accumulator.
- LOAD 6, then SUB 6 -> res_value = 0, zero = 1; then LOAD 10, SRA -> 13 (1101); then SRL -> 6 (0110).
- LOAD 7, then op 12 -> res_err = 1, res_value = 7, flags 0; next NOT -> 8 (1000).
- Backpressure: hold res_ready = 0 for 6 cycles in DONE with a new command asserted -> res_valid and res_* stable, cmd_ready = 0. Release -> new command accepted in the cycle after the response handshake.
- Assert rst_n = 0 during EXEC of ADD 3 after LOAD 2 -> no response; after release, ADD 1 returns 1.
